lcd_reader: RTL and testbench

LCD_READER -- requirements
Module: lcd_reader

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_reader_if.sv | 29 ++
 rtl/lcd_reader.sv | 161 ++++++++++++++++
 tb/tb_lcd_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the character-LCD controllers (reader and writer):
// bus-cycle state encoding, default bus timing constants and a small helper
// used to size phase counters.
// -----------------------------------------------------------------------------
package lcd_pkg;

    // Bus-cycle sequence shared by the LCD read and write controllers.
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnHi,
        StHold,
        StDone
    } lcdState_e;

    // Default timing, in controller clock cycles.
    localparam int unsigned LCD_CLK_DIVIDE = 16;   // LCD_EN high time
    localparam int unsigned LCD_SETUP_CYC  = 2;    // RS/RW setup before LCD_EN rises
    localparam int unsigned LCD_HOLD_CYC   = 2;    // hold after LCD_EN falls
    localparam int unsigned LCD_MAX_POLLS  = 255;  // busy-flag poll limit

    function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// -----------------------------------------------------------------------------
// lcd_reader_if
// LCD pad bus as seen by a read controller.
//   LCD_DATA_IN  8  data bus from the pads
//   LCD_RW       1  1 during a read cycle
//   LCD_EN       1  enable strobe
//   LCD_RS       1  register select
// Modports: master = controller side, slave = panel/pad side.
// -----------------------------------------------------------------------------
interface lcd_reader_if;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    modport master (
        input  LCD_DATA_IN,
        output LCD_RW,
        output LCD_EN,
        output LCD_RS
    );

    modport slave (
        output LCD_DATA_IN,
        input  LCD_RW,
        input  LCD_EN,
        input  LCD_RS
    );
endinterface

// File: rtl/lcd_reader.sv
// -----------------------------------------------------------------------------
// lcd_reader
// Performs one LCD read bus cycle (SETUP -> EN_HI -> HOLD) per rising edge of
// iStart, or, in poll mode with iRS=0, repeats reads until the busy flag
// (bit 7) clears or MAX_POLLS reads have been made.
// Ports:
//   iCLK, iRST_N  clock, asynchronous active-low reset
//   iStart        read request (rising edge only)
//   iRS           0 = busy-flag/address read, 1 = data-RAM read
//   iPoll         with iRS=0: poll until busy clears
//   oDATA         last sampled byte
//   oBusy         read sequence in progress
//   oDone         completion level, cleared on accepted start
//   oTimeout      completion was by poll limit with busy still set
//   lcd           pad bus (LCD_DATA_IN, LCD_RW, LCD_EN, LCD_RS)
// -----------------------------------------------------------------------------
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_Divide = LCD_CLK_DIVIDE,
    parameter int unsigned SETUP_CYC  = LCD_SETUP_CYC,
    parameter int unsigned HOLD_CYC   = LCD_HOLD_CYC,
    parameter int unsigned MAX_POLLS  = LCD_MAX_POLLS
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iStart,
    input  logic         iRS,
    input  logic         iPoll,
    output logic [7:0]   oDATA,
    output logic         oBusy,
    output logic         oDone,
    output logic         oTimeout,
    lcd_reader_if.master lcd
);

    localparam int unsigned PhaseMax = maxOf3(SETUP_CYC, CLK_Divide, HOLD_CYC);
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
    localparam int unsigned PollW    = $clog2(MAX_POLLS + 1);

    localparam logic [PhaseW-1:0] SetupLast = PhaseW'(SETUP_CYC - 1);
    localparam logic [PhaseW-1:0] EnLast    = PhaseW'(CLK_Divide - 1);
    localparam logic [PhaseW-1:0] HoldLast  = PhaseW'(HOLD_CYC - 1);
    localparam logic [PollW-1:0]  PollLast  = PollW'(MAX_POLLS - 1);

    lcdState_e         stateQ, stateD;
    logic [PhaseW-1:0] phaseQ, phaseD;
    logic [PollW-1:0]  pollCntQ, pollCntD;
    logic              rsLatQ, rsLatD;
    logic              pollModeQ, pollModeD;
    logic [7:0]        dataD;
    logic              doneD, timeoutD, busyD;
    logic              startQ, startValidQ;
    logic              startEdge;

    // startValidQ masks the first cycle after reset so that iStart held high
    // across reset release is not mistaken for a new request.
    assign startEdge = startValidQ & ~startQ & iStart;

    always_comb begin
        stateD    = stateQ;
        phaseD    = phaseQ;
        pollCntD  = pollCntQ;
        rsLatD    = rsLatQ;
        pollModeD = pollModeQ;
        dataD     = oDATA;
        doneD     = oDone;
        timeoutD  = oTimeout;

        unique case (stateQ)
            StIdle: begin
                if (startEdge) begin
                    stateD    = StSetup;
                    phaseD    = '0;
                    pollCntD  = '0;
                    rsLatD    = iRS;
                    pollModeD = iPoll & ~iRS;
                    doneD     = 1'b0;
                    timeoutD  = 1'b0;
                end
            end
            StSetup: begin
                if (phaseQ == SetupLast) begin
                    phaseD = '0;
                    stateD = StEnHi;
                end else begin
                    phaseD = phaseQ + PhaseW'(1);
                end
            end
            StEnHi: begin
                if (phaseQ == EnLast) begin
                    phaseD = '0;
                    dataD  = lcd.LCD_DATA_IN;
                    stateD = StHold;
                end else begin
                    phaseD = phaseQ + PhaseW'(1);
                end
            end
            StHold: begin
                if (phaseQ == HoldLast) begin
                    phaseD = '0;
                    if (pollModeQ && oDATA[7] && (pollCntQ < PollLast)) begin
                        pollCntD = pollCntQ + PollW'(1);
                        stateD   = StSetup;
                    end else begin
                        stateD   = StDone;
                        doneD    = 1'b1;
                        timeoutD = pollModeQ & oDATA[7];
                    end
                end else begin
                    phaseD = phaseQ + PhaseW'(1);
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        busyD = (stateD == StSetup) || (stateD == StEnHi) || (stateD == StHold);
    end

    // Pad outputs are registered from the next state so LCD_EN is glitch-free
    // and aligned exactly with the EN_HI state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateQ      <= StIdle;
            phaseQ      <= '0;
            pollCntQ    <= '0;
            rsLatQ      <= 1'b0;
            pollModeQ   <= 1'b0;
            startQ      <= 1'b0;
            startValidQ <= 1'b0;
            oDATA       <= 8'h00;
            oDone       <= 1'b0;
            oTimeout    <= 1'b0;
            oBusy       <= 1'b0;
            lcd.LCD_EN  <= 1'b0;
            lcd.LCD_RW  <= 1'b0;
            lcd.LCD_RS  <= 1'b0;
        end else begin
            stateQ      <= stateD;
            phaseQ      <= phaseD;
            pollCntQ    <= pollCntD;
            rsLatQ      <= rsLatD;
            pollModeQ   <= pollModeD;
            startQ      <= iStart;
            startValidQ <= 1'b1;
            oDATA       <= dataD;
            oDone       <= doneD;
            oTimeout    <= timeoutD;
            oBusy       <= busyD;
            lcd.LCD_EN  <= (stateD == StEnHi);
            lcd.LCD_RW  <= busyD;
            lcd.LCD_RS  <= busyD & rsLatD;
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_reader
// Self-checking bench for lcd_reader. A panel model drives LCD_DATA_IN from a
// per-transaction table of read values (one entry per EN pulse); a reference
// model derives the number of reads, final byte, timeout flag and completion
// latency directly from the timing parameters.
// -----------------------------------------------------------------------------
module tb_lcd_reader;
    import lcd_pkg::*;

    localparam int unsigned CLK_DIV  = 16;
    localparam int unsigned SETUP    = 2;
    localparam int unsigned HOLD     = 2;
    localparam int unsigned MAXP     = 4;
    localparam int unsigned READ_LEN = SETUP + CLK_DIV + HOLD;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iStart = 1'b0;
    logic       iRS = 1'b0;
    logic       iPoll = 1'b0;
    logic [7:0] oDATA;
    logic       oBusy;
    logic       oDone;
    logic       oTimeout;

    lcd_reader_if bus ();

    lcd_reader #(
        .CLK_Divide(CLK_DIV),
        .SETUP_CYC (SETUP),
        .HOLD_CYC  (HOLD),
        .MAX_POLLS (MAXP)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iStart  (iStart),
        .iRS     (iRS),
        .iPoll   (iPoll),
        .oDATA   (oDATA),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oTimeout(oTimeout),
        .lcd     (bus.master)
    );

    always #5 iCLK = ~iCLK;

    int errCnt = 0;
    int chkCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Panel model: read k of a transaction returns padSeq[k]; the bus shows
    // junk while LCD_EN is low so late/early capture is visible.
    logic [7:0] padSeq [8];
    int         enFalls = 0;
    int         readBase = 0;
    int         padIdx;

    always @(negedge bus.LCD_EN) enFalls++;

    always_comb begin
        padIdx = enFalls - readBase;
        if (padIdx < 0) padIdx = 0;
        if (padIdx > 7) padIdx = 7;
        bus.LCD_DATA_IN = bus.LCD_EN ? padSeq[padIdx] : 8'hC3;
    end

    // Bus monitor: counts EN pulses / high cycles, checks RW and RS while EN is high.
    int   enCycles = 0;
    int   enPulses = 0;
    logic prevEn = 1'b0;
    logic expRs = 1'b0;

    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (bus.LCD_EN) begin
                enCycles++;
                checkVal("enImpliesRw", {31'b0, bus.LCD_RW}, 32'd1);
                checkVal("rsStable", {31'b0, bus.LCD_RS}, {31'b0, expRs});
            end
            if (bus.LCD_EN && !prevEn) enPulses++;
        end
        prevEn = bus.LCD_EN;
    end

    // Reference: number of reads a request makes, given the panel table.
    function automatic int modelReads(input logic rs, input logic poll);
        if (!poll || rs) return 1;
        for (int k = 0; k < int'(MAXP); k++) begin
            if (!padSeq[k][7]) return k + 1;
        end
        return int'(MAXP);
    endfunction

    task automatic doRead(input logic rs, input logic poll, input string tag,
                          input int glitchAt);
        int         reads;
        int         doneK;
        int         pulses0;
        int         cycles0;
        logic [7:0] expData;
        logic       expTo;

        reads   = modelReads(rs, poll);
        expData = padSeq[reads - 1];
        expTo   = poll && !rs && expData[7];

        @(negedge iCLK);
        readBase = enFalls;
        pulses0  = enPulses;
        cycles0  = enCycles;
        expRs    = rs;
        iRS      = rs;
        iPoll    = poll;
        iStart   = 1'b1;
        @(posedge iCLK);
        doneK = -1;
        for (int k = 0; k < reads * int'(READ_LEN) + 50; k++) begin
            @(negedge iCLK);
            if (k == 0) begin
                checkVal({tag, ":busy"}, {31'b0, oBusy}, 32'd1);
                checkVal({tag, ":doneClr"}, {31'b0, oDone}, 32'd0);
                iStart = 1'b0;
            end
            if (glitchAt > 0) begin
                if (k == glitchAt) iStart = 1'b1;
                if (k == glitchAt + 2) iStart = 1'b0;
            end
            if (oDone) begin
                doneK = k;
                break;
            end
        end
        checkVal({tag, ":latency"}, doneK, reads * int'(READ_LEN));
        checkVal({tag, ":data"}, {24'b0, oDATA}, {24'b0, expData});
        checkVal({tag, ":timeout"}, {31'b0, oTimeout}, {31'b0, expTo});
        checkVal({tag, ":busyEnd"}, {31'b0, oBusy}, 32'd0);
        checkVal({tag, ":pulses"}, enPulses - pulses0, reads);
        checkVal({tag, ":enCycles"}, enCycles - cycles0, reads * int'(CLK_DIV));
        iStart = 1'b0;
        repeat (6) @(negedge iCLK);
        checkVal({tag, ":idleBusy"}, {31'b0, oBusy}, 32'd0);
        checkVal({tag, ":holdDone"}, {31'b0, oDone}, 32'd1);
        checkVal({tag, ":holdData"}, {24'b0, oDATA}, {24'b0, expData});
        checkVal({tag, ":noExtra"}, enPulses - pulses0, reads);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses0;
        for (int i = 0; i < 8; i++) padSeq[i] = 8'h00;

        // Reset values
        #2;
        checkVal("rst:en", {31'b0, bus.LCD_EN}, 32'd0);
        checkVal("rst:rw", {31'b0, bus.LCD_RW}, 32'd0);
        checkVal("rst:rs", {31'b0, bus.LCD_RS}, 32'd0);
        checkVal("rst:data", {24'b0, oDATA}, 32'd0);
        checkVal("rst:busy", {31'b0, oBusy}, 32'd0);
        checkVal("rst:done", {31'b0, oDone}, 32'd0);
        checkVal("rst:timeout", {31'b0, oTimeout}, 32'd0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        // Single data read
        for (int i = 0; i < 8; i++) padSeq[i] = 8'h5A;
        doRead(1'b1, 1'b0, "dataRead", 0);

        // Busy-flag poll: busy for three reads, then clear
        padSeq[0] = 8'h80; padSeq[1] = 8'h80; padSeq[2] = 8'h80; padSeq[3] = 8'h07;
        doRead(1'b0, 1'b1, "poll", 0);

        // Poll limit reached with busy stuck
        for (int i = 0; i < 8; i++) padSeq[i] = 8'hFF;
        doRead(1'b0, 1'b1, "pollTimeout", 0);

        // iPoll with iRS=1 is a single read
        for (int i = 0; i < 8; i++) padSeq[i] = 8'h80;
        doRead(1'b1, 1'b1, "pollRs1", 0);

        // Second start edge during EN_HI is dropped
        for (int i = 0; i < 8; i++) padSeq[i] = 8'h3C;
        doRead(1'b1, 1'b0, "ignoredStart", 8);

        // Randomized requests
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++)
                padSeq[i] = {($urandom_range(0, 9) < 6), 7'($urandom)};
            doRead(1'($urandom), 1'($urandom), $sformatf("rand%0d", t), 0);
        end

        // Reset during EN_HI (fifth EN cycle), iStart held high across release
        for (int i = 0; i < 8; i++) padSeq[i] = 8'hA5;
        @(negedge iCLK);
        readBase = enFalls;
        expRs    = 1'b1;
        iRS      = 1'b1;
        iPoll    = 1'b0;
        iStart   = 1'b1;
        @(posedge iCLK);
        for (int k = 0; k <= 6; k++) begin
            @(negedge iCLK);
            if (k == 0) iStart = 1'b0;
        end
        checkVal("midRst:enBefore", {31'b0, bus.LCD_EN}, 32'd1);
        iStart = 1'b1;
        iRST_N = 1'b0;
        #1;
        checkVal("midRst:en", {31'b0, bus.LCD_EN}, 32'd0);
        checkVal("midRst:rw", {31'b0, bus.LCD_RW}, 32'd0);
        checkVal("midRst:rs", {31'b0, bus.LCD_RS}, 32'd0);
        checkVal("midRst:data", {24'b0, oDATA}, 32'd0);
        checkVal("midRst:busy", {31'b0, oBusy}, 32'd0);
        checkVal("midRst:done", {31'b0, oDone}, 32'd0);
        checkVal("midRst:timeout", {31'b0, oTimeout}, 32'd0);
        repeat (3) @(negedge iCLK);
        pulses0 = enPulses;
        iRST_N = 1'b1;
        repeat (30) @(negedge iCLK);
        checkVal("postRst:busy", {31'b0, oBusy}, 32'd0);
        checkVal("postRst:done", {31'b0, oDone}, 32'd0);
        checkVal("postRst:pulses", enPulses - pulses0, 32'd0);
        iStart = 1'b0;
        repeat (2) @(negedge iCLK);

        // Normal operation after reset
        for (int i = 0; i < 8; i++) padSeq[i] = 8'h42;
        doRead(1'b1, 1'b0, "afterRst", 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
